// File: rtl/el2_pkg.sv
// -----------------------------------------------------------------------------
// el2_pkg
// Shared definitions for the SRAM-side end of the DCCM bank export interface:
//   - default bank geometry (bank count, index, data and check-bit widths)
//   - DCCM_WORD_W: width of one stored word, {ecc, data}
//   - per-bank write-request and read-response structs at the default geometry
//   - the sink sequencer state type
// -----------------------------------------------------------------------------
package el2_pkg;

    localparam int unsigned DCCM_NUM_BANKS = 4;
    localparam int unsigned DCCM_ADDR_W    = 10;
    localparam int unsigned DCCM_DATA_W    = 32;
    localparam int unsigned DCCM_ECC_W     = 7;
    localparam int unsigned DCCM_WORD_W    = DCCM_DATA_W + DCCM_ECC_W;

    // One bank's request as presented by the core-side memory wrapper.
    typedef struct packed {
        logic                   clken;
        logic                   wren;
        logic [DCCM_ADDR_W-1:0] addr;
        logic [DCCM_DATA_W-1:0] wr_data;
        logic [DCCM_ECC_W-1:0]  wr_ecc;
    } dccm_bank_wr_t;

    // One bank's registered read response.
    typedef struct packed {
        logic [DCCM_DATA_W-1:0] dout;
        logic [DCCM_ECC_W-1:0]  ecc;
    } dccm_bank_rd_t;

    // Zero-fill sequencer: StInit fills every bank, StReady is terminal.
    typedef enum logic {
        StInit  = 1'b0,
        StReady = 1'b1
    } sink_state_e;

    // Stored words are packed {ecc, data}, so an injector bit index maps
    // directly onto a word bit position.
    function automatic logic inj_bit_in_range(input logic [5:0] bit_idx,
                                              input int unsigned word_w);
        return ({26'd0, bit_idx} < word_w);
    endfunction

endpackage

// File: rtl/el2_dccm_sram_bank.sv
// -----------------------------------------------------------------------------
// el2_dccm_sram_bank
// One single-port DEPTH x WORD_W DCCM bank with a registered read port.
//   clk      : core clock
//   rst_l    : asynchronous active-low reset (read register only, array unreset)
//   i_en     : access enable
//   i_we     : write when enabled, otherwise read
//   i_addr   : word index
//   i_wdata  : write word {ecc, data}
//   i_flip   : XOR mask applied to the word on its way into the read register
//   o_rdata  : registered read word; holds on writes and idle cycles
// -----------------------------------------------------------------------------
module el2_dccm_sram_bank #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WORD_W = 39
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [WORD_W-1:0] i_flip,
    output logic [WORD_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Storage has no reset; the sink's zero-fill sequencer initialises it.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // No write-through: a write leaves the read register untouched. The flip
    // mask only corrupts the response, never the stored word.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr] ^ i_flip;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/el2_dccm_sram_sink.sv
// -----------------------------------------------------------------------------
// el2_dccm_sram_sink
// SRAM-side responder for the DCCM bank export interface.
//   clk, rst_l          : core clock, asynchronous active-low reset
//   dccm_clken          : per-bank access enable
//   dccm_wren_bank      : per-bank write (only meaningful with clken)
//   dccm_addr_bank      : per-bank word index
//   dccm_wr_data_bank   : per-bank write data
//   dccm_wr_ecc_bank    : per-bank write check bits
//   dccm_bank_dout      : per-bank registered read data
//   dccm_bank_ecc       : per-bank registered read check bits
//   init_done           : zero-fill finished, core traffic accepted
//   inj_req/bank/bit    : arm a one-shot bit flip on the next read of a bank
//   inj_busy            : injection armed and not yet consumed
// After reset all banks are zero-filled (data 0, ECC 0) one index per cycle;
// core requests are ignored until that completes.
// -----------------------------------------------------------------------------
module el2_dccm_sram_sink
    import el2_pkg::*;
#(
    parameter int unsigned NUM_BANKS = DCCM_NUM_BANKS,
    parameter int unsigned ADDR_W    = DCCM_ADDR_W,
    parameter int unsigned DATA_W    = DCCM_DATA_W,
    parameter int unsigned ECC_W     = DCCM_ECC_W,
    localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_l,
    input  logic [NUM_BANKS-1:0]              dccm_clken,
    input  logic [NUM_BANKS-1:0]              dccm_wren_bank,
    input  logic [NUM_BANKS-1:0][ADDR_W-1:0]  dccm_addr_bank,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]  dccm_wr_data_bank,
    input  logic [NUM_BANKS-1:0][ECC_W-1:0]   dccm_wr_ecc_bank,
    output logic [NUM_BANKS-1:0][DATA_W-1:0]  dccm_bank_dout,
    output logic [NUM_BANKS-1:0][ECC_W-1:0]   dccm_bank_ecc,
    output logic                              init_done,
    input  logic                              inj_req,
    input  logic [BANK_W-1:0]                 inj_bank,
    input  logic [5:0]                        inj_bit,
    output logic                              inj_busy
);

    localparam int unsigned WORD_W = DATA_W + ECC_W;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } bank_req_t;

    // -------------------------------------------------------------------------
    // Zero-fill sequencer
    // -------------------------------------------------------------------------
    sink_state_e       r_state;
    sink_state_e       w_state_d;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_d;
    logic              w_in_init;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= StInit;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StInit: begin
                w_cnt_d = r_cnt + 1'b1;
                // Last index is written on this edge; traffic opens next cycle.
                if (&r_cnt) begin
                    w_state_d = StReady;
                end
            end
            StReady: begin
                w_state_d = StReady;
            end
            default: begin
                w_state_d = StInit;
            end
        endcase
    end

    assign w_in_init = (r_state == StInit);
    assign init_done = (r_state == StReady);

    // -------------------------------------------------------------------------
    // Bank request mux: the sequencer owns every bank during the fill
    // -------------------------------------------------------------------------
    bank_req_t w_req [NUM_BANKS];

    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            w_req[b].en    = dccm_clken[b];
            w_req[b].we    = dccm_wren_bank[b];
            w_req[b].addr  = dccm_addr_bank[b];
            w_req[b].wdata = {dccm_wr_ecc_bank[b], dccm_wr_data_bank[b]};
            if (w_in_init) begin
                w_req[b].en    = 1'b1;
                w_req[b].we    = 1'b1;
                w_req[b].addr  = r_cnt;
                w_req[b].wdata = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // One-shot bit-flip injector
    // -------------------------------------------------------------------------
    logic                 r_inj_busy;
    logic [BANK_W-1:0]    r_inj_bank;
    logic [5:0]           r_inj_bit;
    logic                 w_inj_accept;
    logic                 w_inj_consume;
    logic [WORD_W-1:0]    w_flip_mask;
    logic [NUM_BANKS-1:0] w_core_rd;
    logic [NUM_BANKS-1:0] w_inj_hit;
    logic [WORD_W-1:0]    w_flip [NUM_BANKS];

    // Requests while armed or naming a bit outside the stored word are dropped.
    assign w_inj_accept = inj_req && !r_inj_busy && inj_bit_in_range(inj_bit, WORD_W);

    // Word is {ecc, data}, so the bit index selects the word bit directly.
    assign w_flip_mask = {{(WORD_W-1){1'b0}}, 1'b1} << r_inj_bit;

    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            w_core_rd[b] = !w_in_init && dccm_clken[b] && !dccm_wren_bank[b];
            w_inj_hit[b] = r_inj_busy && (r_inj_bank == BANK_W'(b)) && w_core_rd[b];
            w_flip[b]    = w_inj_hit[b] ? w_flip_mask : '0;
        end
    end

    assign w_inj_consume = |w_inj_hit;

    // Arm and consume are mutually exclusive: arming needs busy low,
    // consuming needs busy high.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_inj_busy <= 1'b0;
            r_inj_bank <= '0;
            r_inj_bit  <= '0;
        end else if (w_inj_consume) begin
            r_inj_busy <= 1'b0;
        end else if (w_inj_accept) begin
            r_inj_busy <= 1'b1;
            r_inj_bank <= inj_bank;
            r_inj_bit  <= inj_bit;
        end
    end

    assign inj_busy = r_inj_busy;

    // -------------------------------------------------------------------------
    // Banks
    // -------------------------------------------------------------------------
    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        logic [WORD_W-1:0] w_rdata;

        el2_dccm_sram_bank #(
            .ADDR_W (ADDR_W),
            .WORD_W (WORD_W)
        ) u_bank (
            .clk     (clk),
            .rst_l   (rst_l),
            .i_en    (w_req[gb].en),
            .i_we    (w_req[gb].we),
            .i_addr  (w_req[gb].addr),
            .i_wdata (w_req[gb].wdata),
            .i_flip  (w_flip[gb]),
            .o_rdata (w_rdata)
        );

        assign dccm_bank_dout[gb] = w_rdata[DATA_W-1:0];
        assign dccm_bank_ecc[gb]  = w_rdata[WORD_W-1:DATA_W];
    end

endmodule

// File: tb/tb_el2_dccm_sram_sink.sv
// -----------------------------------------------------------------------------
// tb_el2_dccm_sram_sink
// Self-checking bench for el2_dccm_sram_sink at default geometry
// (4 banks, 1024 words, 32 data + 7 ECC bits). Inputs change on the falling
// edge; outputs are compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_el2_dccm_sram_sink;

    logic             clk = 1'b0;
    logic             rst_l;
    logic [3:0]       clken;
    logic [3:0]       wren;
    logic [3:0][9:0]  addr;
    logic [3:0][31:0] wd;
    logic [3:0][6:0]  wecc;
    logic [3:0][31:0] dout;
    logic [3:0][6:0]  ecc;
    logic             init_done;
    logic             inj_req;
    logic [1:0]       inj_bank;
    logic [5:0]       inj_bit;
    logic             inj_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    el2_dccm_sram_sink u_dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .dccm_clken        (clken),
        .dccm_wren_bank    (wren),
        .dccm_addr_bank    (addr),
        .dccm_wr_data_bank (wd),
        .dccm_wr_ecc_bank  (wecc),
        .dccm_bank_dout    (dout),
        .dccm_bank_ecc     (ecc),
        .init_done         (init_done),
        .inj_req           (inj_req),
        .inj_bank          (inj_bank),
        .inj_bit           (inj_bit),
        .inj_busy          (inj_busy)
    );

    typedef struct {
        logic [3:0]       ce;
        logic [3:0]       we;
        logic [3:0][9:0]  a;
        logic [3:0][31:0] d;
        logic [3:0][6:0]  e;
        logic [3:0][31:0] xd;
        logic [3:0][6:0]  xe;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start a vector as idle, with expected outputs held from the previous one.
    task automatic vinit(input int i);
        vecs[i].ce = '0;
        vecs[i].we = '0;
        vecs[i].a  = '0;
        vecs[i].d  = '0;
        vecs[i].e  = '0;
        vecs[i].xd = (i == 0) ? '0 : vecs[i-1].xd;
        vecs[i].xe = (i == 0) ? '0 : vecs[i-1].xe;
    endtask

    task automatic vset(input int i, input int b, input bit w, input logic [9:0] a,
                        input logic [31:0] d, input logic [6:0] e);
        vecs[i].ce[b] = 1'b1;
        vecs[i].we[b] = w;
        vecs[i].a[b]  = a;
        vecs[i].d[b]  = d;
        vecs[i].e[b]  = e;
    endtask

    task automatic vexp(input int i, input int b, input logic [31:0] d, input logic [6:0] e);
        vecs[i].xd[b] = d;
        vecs[i].xe[b] = e;
    endtask

    task automatic go_idle();
        clken   = '0;
        wren    = '0;
        inj_req = 1'b0;
    endtask

    // One access cycle on bank b; called and returns on a falling edge.
    task automatic acc1(input int b, input bit w, input logic [9:0] a,
                        input logic [31:0] d, input logic [6:0] e);
        clken    = '0;
        wren     = '0;
        clken[b] = 1'b1;
        wren[b]  = w;
        addr[b]  = a;
        wd[b]    = d;
        wecc[b]  = e;
        @(negedge clk);
        go_idle();
    endtask

    task automatic idle1();
        @(negedge clk);
        go_idle();
    endtask

    task automatic arm(input logic [1:0] b, input logic [5:0] bt);
        inj_req  = 1'b1;
        inj_bank = b;
        inj_bit  = bt;
    endtask

    // Count rising edges until init_done; optionally attempts a core write
    // to bank 3 at edge wr_at to show it is ignored during the fill.
    task automatic wait_init(input int wr_at, input logic [9:0] wa, output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 3000) begin
            if (n == wr_at) begin
                clken[3] = 1'b1;
                wren[3]  = 1'b1;
                addr[3]  = wa;
                wd[3]    = 32'hA5A5A5A5;
                wecc[3]  = 7'h55;
            end else begin
                clken = '0;
                wren  = '0;
            end
            @(negedge clk);
            n++;
        end
        go_idle();
    endtask

    initial begin
        int n;

        rst_l    = 1'b0;
        clken    = '0;
        wren     = '0;
        addr     = '0;
        wd       = '0;
        wecc     = '0;
        inj_req  = 1'b0;
        inj_bank = '0;
        inj_bit  = '0;

        // Vector table: each entry is one cycle of traffic and the outputs
        // expected one edge later.
        vinit(0); vset(0, 2, 0, 10'd1023, 0, 0);
        vinit(1); vset(1, 1, 1, 10'h155, 32'hDEADBEEF, 7'h5A);
        vinit(2); vset(2, 1, 0, 10'h155, 0, 0); vexp(2, 1, 32'hDEADBEEF, 7'h5A);
        vinit(3);
        vset(3, 0, 1, 10'h2A0, 32'h11111111, 7'h01);
        vset(3, 1, 1, 10'h2A0, 32'h22222222, 7'h02);
        vset(3, 2, 1, 10'h2A0, 32'h33333333, 7'h03);
        vset(3, 3, 1, 10'h2A0, 32'h44444444, 7'h04);
        vinit(4);
        for (int b = 0; b < 4; b++) vset(4, b, 0, 10'h2A0, 0, 0);
        vexp(4, 0, 32'h11111111, 7'h01);
        vexp(4, 1, 32'h22222222, 7'h02);
        vexp(4, 2, 32'h33333333, 7'h03);
        vexp(4, 3, 32'h44444444, 7'h04);
        vinit(5);
        vinit(6);
        vset(6, 0, 0, 10'h155, 0, 0); vexp(6, 0, 32'h0, 7'h00);
        vset(6, 3, 1, 10'h155, 32'hCAFEF00D, 7'h33);
        vinit(7);
        vset(7, 3, 0, 10'h155, 0, 0); vexp(7, 3, 32'hCAFEF00D, 7'h33);
        vset(7, 0, 0, 10'h2A0, 0, 0); vexp(7, 0, 32'h11111111, 7'h01);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_ecc", ecc, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_inj_busy", inj_busy, 0);

        rst_l = 1'b1;
        wait_init(-1, 10'd0, n);
        chk("init_edges", n, 1024);
        chk("init_dout_zero", dout, 0);

        for (int i = 0; i < NVEC; i++) begin
            clken = vecs[i].ce;
            wren  = vecs[i].we;
            addr  = vecs[i].a;
            wd    = vecs[i].d;
            wecc  = vecs[i].e;
            @(negedge clk);
            go_idle();
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].xd);
            chk($sformatf("vec%0d_ecc", i), ecc, vecs[i].xe);
        end

        // Data-bit injection, then a clean re-read
        arm(0, 6'd3); idle1();
        chk("inj_d_busy_set", inj_busy, 1);
        acc1(0, 0, 10'h300, 0, 0);
        chk("inj_d_dout", dout[0], 32'h00000008);
        chk("inj_d_ecc", ecc[0], 7'h00);
        chk("inj_d_busy_clr", inj_busy, 0);
        acc1(0, 0, 10'h300, 0, 0);
        chk("inj_d_reread", dout[0], 32'h0);

        // ECC-bit injection; a write and another bank's read do not consume it
        arm(0, 6'd35); idle1();
        chk("inj_e_busy_set", inj_busy, 1);
        acc1(0, 1, 10'h301, 32'h12345678, 7'h00);
        chk("inj_e_wr_keep", inj_busy, 1);
        acc1(1, 0, 10'h155, 0, 0);
        chk("inj_e_other_bank", dout[1], 32'hDEADBEEF);
        chk("inj_e_other_keep", inj_busy, 1);
        acc1(0, 0, 10'h300, 0, 0);
        chk("inj_e_dout", dout[0], 32'h0);
        chk("inj_e_ecc", ecc[0], 7'h08);
        chk("inj_e_busy_clr", inj_busy, 0);

        // Out-of-range bits are dropped
        arm(0, 6'd45); idle1();
        chk("inj_45_drop", inj_busy, 0);
        arm(0, 6'd39); idle1();
        chk("inj_39_drop", inj_busy, 0);
        acc1(0, 0, 10'h301, 0, 0);
        chk("inj_drop_clean", {ecc[0], dout[0]}, {7'h00, 32'h12345678});

        // Highest ECC bit; a second request while armed is ignored
        arm(2, 6'd38); idle1();
        chk("inj_38_busy", inj_busy, 1);
        arm(2, 6'd0); idle1();
        chk("inj_retain_busy", inj_busy, 1);
        acc1(2, 0, 10'h2A0, 0, 0);
        chk("inj_retain_word", {ecc[2], dout[2]}, {7'h43, 32'h33333333});
        chk("inj_retain_clr", inj_busy, 0);
        acc1(2, 0, 10'h2A0, 0, 0);
        chk("inj_retain_reread", {ecc[2], dout[2]}, {7'h03, 32'h33333333});

        // Request coincident with a read of the same bank leaves that read clean
        arm(3, 6'd0);
        acc1(3, 0, 10'h155, 0, 0);
        chk("inj_coinc_clean", dout[3], 32'hCAFEF00D);
        chk("inj_coinc_busy", inj_busy, 1);
        acc1(3, 0, 10'h155, 0, 0);
        chk("inj_coinc_next", dout[3], 32'hCAFEF00C);
        chk("inj_coinc_clr", inj_busy, 0);

        // Asynchronous reset clears outputs mid-cycle
        rst_l = 1'b0;
        #2;
        chk("async_rst_dout", dout, 0);
        chk("async_rst_ecc", ecc, 0);
        chk("async_rst_init_done", init_done, 0);
        @(negedge clk);
        rst_l = 1'b1;

        // Partial fill to index 500, with an ignored core write at index 7
        for (int k = 0; k < 500; k++) begin
            if (k == 100) begin
                clken[3] = 1'b1;
                wren[3]  = 1'b1;
                addr[3]  = 10'd7;
                wd[3]    = 32'h5A5A5A5A;
                wecc[3]  = 7'h2A;
            end else begin
                clken = '0;
                wren  = '0;
            end
            @(negedge clk);
        end
        go_idle();
        chk("midinit_not_done", init_done, 0);
        chk("midinit_dout_zero", dout, 0);

        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        wait_init(200, 10'd8, n);
        chk("reinit_edges", n, 1024);

        acc1(3, 0, 10'd7, 0, 0);
        chk("init_wr7_ignored", {ecc[3], dout[3]}, 0);
        acc1(3, 0, 10'd8, 0, 0);
        chk("init_wr8_ignored", {ecc[3], dout[3]}, 0);
        acc1(0, 0, 10'h2A0, 0, 0);
        chk("refill_2a0", {ecc[0], dout[0]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/el2_dccm_sram_sink.md
Name: el2_dccm_sram_sink

Overview:
- Responder (SRAM-side) end of the DCCM bank export interface.
- Consumes per-bank clock-enable, write-enable, address, data and ECC from the core's memory wrapper; returns registered per-bank read data and ECC.
- After reset, a sequencer zero-fills every bank with valid ECC before accepting traffic.
- A one-shot bit-flip injector corrupts a single read response so the LSU ECC paths can be exercised.

Parameters:
- NUM_BANKS, 4, number of independent DCCM banks.
- ADDR_W, 10, per-bank index width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, data bits per word.
- ECC_W, 7, SECDED check bits per word.

Ports:
- clk  input  1  core clock.
- rst_l  input  1  asynchronous active-low reset.
- dccm_clken  input  NUM_BANKS  per-bank access enable.
- dccm_wren_bank  input  NUM_BANKS  per-bank write (valid only with clken).
- dccm_addr_bank  input  NUM_BANKS x ADDR_W  per-bank word index.
- dccm_wr_data_bank  input  NUM_BANKS x DATA_W  write data.
- dccm_wr_ecc_bank  input  NUM_BANKS x ECC_W  write check bits.
- dccm_bank_dout  output  NUM_BANKS x DATA_W  read data.
- dccm_bank_ecc  output  NUM_BANKS x ECC_W  read check bits.
- init_done  output  1  zero-fill complete; banks accept core traffic.
- inj_req  input  1  single-cycle pulse arming an injection.
- inj_bank  input  $clog2(NUM_BANKS)  target bank.
- inj_bit  input  6  bit to flip: 0..DATA_W-1 selects data, DATA_W..DATA_W+ECC_W-1 selects ECC.
- inj_busy  output  1  injection armed, not yet consumed.

Behaviour:
- Reset values:
  - dccm_bank_dout, dccm_bank_ecc = 0; init_done = 0; inj_busy = 0.
  - FSM enters INIT with counter 0.
  - Array contents are not reset.
- FSM, INIT:
  - Each cycle, all banks write data 0 and ECC 0 at index cnt; cnt increments.
  - At cnt == DEPTH-1, that write completes and the FSM goes to READY.
  - Core clken/wren are ignored and outputs hold 0.
- FSM, READY:
  - init_done = 1, registered from the state, so it is first high DEPTH rising edges after the first edge with rst_l high.
  - READY is terminal until reset.
- Reset asserted mid-INIT: asynchronously returns to INIT, cnt = 0; fill restarts from index 0.
- Core write (READY, clken & wren): array[addr] <= {ecc, data} at the edge; that bank's outputs hold their previous value (no write-through).
- Core read (READY, clken & ~wren): outputs update at the next edge with array[addr]. Latency is 1 cycle.
- Idle (clken = 0): outputs hold.
- Banks are fully independent; simultaneous accesses to all banks are legal.
- Injection:
  - inj_req while inj_busy = 0 and inj_bit < DATA_W+ECC_W latches bank/bit and sets inj_busy the next cycle.
  - inj_req while busy, or with an out-of-range bit, is dropped.
  - The next READY read of the latched bank returns the word with the selected bit inverted; inj_busy clears at the same edge.
  - Storage is never modified; a re-read returns clean data.
  - inj_req coincident with a read to the same bank does not affect that read.
  - Writes do not consume an armed injection.
- Address width is exact: no wrap or range checking is required.

Decomposition:
- el2_pkg: per-bank write/read struct typedefs, and localparam DCCM_WORD_W = DATA_W+ECC_W.
- Sub-module el2_dccm_sram_bank: one single-port DEPTH x DCCM_WORD_W array with 1-cycle registered read and output hold. Instantiated NUM_BANKS times via generate.
- The top level owns the INIT FSM, the zero-fill mux, and the injector.

Test Plan:
- Release rst_l, DEPTH = 1024 → init_done rises exactly 1024 edges later; reading bank 2 index 1023 returns data 0x00000000, ECC 0x00.
- Write bank 1 index 0x155 data 0xDEADBEEF, ECC 0x5A; read it the following cycle → dout 0xDEADBEEF, ECC 0x5A one edge after the read; dout unchanged during the write cycle.
- Read the same index on all 4 banks in one cycle after distinct writes (0x11111111 to 0x44444444) → each bank returns its own value, no cross-talk.
- inj_req bank 0, bit 3, then read a word holding 0x00000000 → dout 0x00000008, inj_busy 1→0 at that edge. Second read → 0x00000000. Then inj_bit 35 → ECC bit 3 flipped, data clean.
- inj_req with inj_bit 45 → inj_busy stays 0 and reads are clean. inj_req while busy → the original injection is retained.
- Assert rst_l at cnt = 500 during INIT, then release → init_done low, rises 1024 edges after release; a core write issued during INIT has no effect (the location reads 0).
